// File: rtl/stack_sequencer_pkg.sv
// Shared constants for the stack sequencer slice.
// Opcode/mode encodings and the default stack size sit behind the CONSTANTS
// include guard so any other file defining the same set stays consistent.
// Optional feature macro used elsewhere in this slice: STACKSEQ_ARITH_EN.
`ifndef CONSTANTS
`define CONSTANTS
`define STACK_SIZE 8
`define OP_NOP   3'd0
`define OP_PUSH  3'd1
`define OP_POP   3'd2
`define OP_DUP   3'd3
`define OP_SWAP  3'd4
`define OP_ADD   3'd5
`define OP_SUB   3'd6
`define OP_CLEAR 3'd7
`define MODE_HOLD 3'd0
`define MODE_PUSH 3'd1
`define MODE_POP  3'd2
`define MODE_LOAD 3'd3
`endif

package stack_sequencer_pkg;

  localparam int STACK_SIZE = `STACK_SIZE;
  localparam int DATA_W     = 4;

  typedef enum logic [2:0] {
    CMD_NOP   = `OP_NOP,
    CMD_PUSH  = `OP_PUSH,
    CMD_POP   = `OP_POP,
    CMD_DUP   = `OP_DUP,
    CMD_SWAP  = `OP_SWAP,
    CMD_ADD   = `OP_ADD,
    CMD_SUB   = `OP_SUB,
    CMD_CLEAR = `OP_CLEAR
  } op_e;

  localparam logic [2:0] MODE_HOLD = `MODE_HOLD;
  localparam logic [2:0] MODE_PUSH = `MODE_PUSH;
  localparam logic [2:0] MODE_POP  = `MODE_POP;
  localparam logic [2:0] MODE_LOAD = `MODE_LOAD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_PUSH = 2'd1,
    S_POP  = 2'd2,
    S_LOAD = 2'd3
  } state_e;

endpackage

// File: rtl/stack_sequencer_alu.sv
// stack_alu: 4-bit add/subtract of the two top stack entries.
// Result is s+t or s-t modulo 16; carry is bit 4 of the 5-bit sum or
// difference (a set bit on subtract means a borrow occurred).
// Only built when STACKSEQ_ARITH_EN is defined.
`ifdef STACKSEQ_ARITH_EN
module stack_alu (
  input  logic [3:0] s,
  input  logic [3:0] t,
  input  logic       sub,
  output logic [3:0] result,
  output logic       carry
);

  logic [4:0] wide;

  // Widen by one bit so the carry/borrow falls out of the top bit.
  always_comb begin
    wide = '0;
    if (sub) wide = {1'b0, s} - {1'b0, t};
    else     wide = {1'b0, s} + {1'b0, t};
  end

  assign result = wide[3:0];
  assign carry  = wide[4];

endmodule
`endif

// File: rtl/stack_sequencer.sv
// stack_sequencer: Moore FSM that turns stack commands into a sequence of
// HOLD/PUSH/POP/LOAD steps for an external stack register, tracking the
// logical depth, a sticky error flag and the last arithmetic carry.
// Optional feature: define STACKSEQ_ARITH_EN to enable ADD/SUB; otherwise
// those opcodes are flagged as errors and carry reads 0.
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter int DEPTH_MAX = STACK_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  output logic       cmd_ready,
  input  logic [3:0] top_word,
  input  logic [3:0] second_word,
  output logic [2:0] stk_mode,
  output logic [3:0] stk_in_word,
  output logic [3:0] depth,
  output logic       err,
  output logic       carry
);

  localparam logic [3:0] DEPTH_TOP = 4'(DEPTH_MAX);

  state_e     state;
  op_e        op_q;
  op_e        op_in;
  logic [3:0] t_q;
  logic [3:0] s_q;
  logic [3:0] res_q;
  logic       carry_q;
  logic       bad;
  logic [3:0] alu_res;
  logic       alu_cy;

  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign carry     = carry_q;

`ifdef STACKSEQ_ARITH_EN
  stack_alu u_alu (
    .s      (second_word),
    .t      (top_word),
    .sub    (op_in == CMD_SUB),
    .result (alu_res),
    .carry  (alu_cy)
  );
`else
  assign alu_res = '0;
  assign alu_cy  = 1'b0;
`endif

  // Decide whether the offered command is illegal at the current depth.
  always_comb begin
    bad = 1'b0;
    case (op_in)
      CMD_PUSH, CMD_DUP: bad = (depth == DEPTH_TOP);
      CMD_POP:           bad = (depth == 4'd0);
      CMD_SWAP:          bad = (depth < 4'd2);
`ifdef STACKSEQ_ARITH_EN
      CMD_ADD, CMD_SUB:  bad = (depth < 4'd2);
`else
      CMD_ADD, CMD_SUB:  bad = 1'b1;
`endif
      default:           bad = 1'b0;
    endcase
  end

  // Sequencer FSM: accept in IDLE, then walk the step list for the latched op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= CMD_NOP;
      stk_mode    <= MODE_HOLD;
      stk_in_word <= '0;
      depth       <= '0;
      err         <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= op_in;
            t_q  <= top_word;
            s_q  <= second_word;
            if (op_in == CMD_CLEAR) begin
              depth   <= '0;
              err     <= 1'b0;
              carry_q <= 1'b0;
            end else if (op_in == CMD_NOP) begin
              state <= IDLE;
            end else if (bad) begin
              err <= 1'b1;
            end else begin
              case (op_in)
                CMD_PUSH: begin
                  state       <= S_PUSH;
                  stk_mode    <= MODE_PUSH;
                  stk_in_word <= cmd_data;
                  depth       <= depth + 4'd1;
                end
                CMD_DUP: begin
                  state       <= S_PUSH;
                  stk_mode    <= MODE_PUSH;
                  stk_in_word <= top_word;
                  depth       <= depth + 4'd1;
                end
                CMD_POP: begin
                  state       <= S_POP;
                  stk_mode    <= MODE_POP;
                  stk_in_word <= '0;
                  depth       <= depth - 4'd1;
                end
                CMD_ADD, CMD_SUB: begin
                  state       <= S_POP;
                  stk_mode    <= MODE_POP;
                  stk_in_word <= '0;
                  depth       <= depth - 4'd1;
                  res_q       <= alu_res;
                  carry_q     <= alu_cy;
                end
                CMD_SWAP: begin
                  state       <= S_POP;
                  stk_mode    <= MODE_POP;
                  stk_in_word <= '0;
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
        S_POP: begin
          if (op_q == CMD_ADD || op_q == CMD_SUB) begin
            state       <= S_LOAD;
            stk_mode    <= MODE_LOAD;
            stk_in_word <= res_q;
          end else if (op_q == CMD_SWAP) begin
            state       <= S_LOAD;
            stk_mode    <= MODE_LOAD;
            stk_in_word <= t_q;
          end else begin
            state       <= IDLE;
            stk_mode    <= MODE_HOLD;
            stk_in_word <= '0;
          end
        end
        S_LOAD: begin
          if (op_q == CMD_SWAP) begin
            state       <= S_PUSH;
            stk_mode    <= MODE_PUSH;
            stk_in_word <= s_q;
          end else begin
            state       <= IDLE;
            stk_mode    <= MODE_HOLD;
            stk_in_word <= '0;
          end
        end
        S_PUSH: begin
          state       <= IDLE;
          stk_mode    <= MODE_HOLD;
          stk_in_word <= '0;
        end
        default: begin
          state       <= IDLE;
          stk_mode    <= MODE_HOLD;
          stk_in_word <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a behavioural stack register closes the loop,
// expected stack steps are queued by the stimulus and checked by a monitor
// whenever stk_mode shows a non-HOLD step.
module tb_stack_sequencer;

  localparam int DMAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic [3:0] top_word;
  logic [3:0] second_word;
  logic [2:0] stk_mode;
  logic [3:0] stk_in_word;
  logic [3:0] depth;
  logic       err;
  logic       carry;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp_q[$];
  logic [3:0] stk [DMAX];

  always #5 clk = ~clk;

  stack_sequencer #(.DEPTH_MAX(DMAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_op      (cmd_op),
    .cmd_data    (cmd_data),
    .cmd_ready   (cmd_ready),
    .top_word    (top_word),
    .second_word (second_word),
    .stk_mode    (stk_mode),
    .stk_in_word (stk_in_word),
    .depth       (depth),
    .err         (err),
    .carry       (carry)
  );

  // Behavioural stack register driven by stk_mode/stk_in_word.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DMAX; i++) stk[i] <= 4'd0;
    end else begin
      case (stk_mode)
        3'd1: begin
          for (int i = DMAX - 1; i > 0; i--) stk[i] <= stk[i-1];
          stk[0] <= stk_in_word;
        end
        3'd2: begin
          for (int i = 0; i < DMAX - 1; i++) stk[i] <= stk[i+1];
          stk[DMAX-1] <= 4'd0;
        end
        3'd3: stk[0] <= stk_in_word;
        default: ;
      endcase
    end
  end

  assign top_word    = stk[0];
  assign second_word = stk[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // Monitor: every visible stack step must match the next queued expectation.
  always @(negedge clk) begin
    if (stk_mode != 3'd0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step_mode", {29'd0, stk_mode}, 32'd0);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        chk("step_mode", {29'd0, stk_mode}, {29'd0, e[6:4]});
        chk("step_word", {28'd0, stk_in_word}, {28'd0, e[3:0]});
      end
    end
  end

  task automatic expect_step(input logic [2:0] mode, input logic [3:0] word);
    exp_q.push_back({mode, word});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (cmd_ready !== 1'b1) chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] d);
    wait_idle();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
  endtask

  task automatic push(input logic [3:0] d);
    expect_step(3'd1, d);
    send(3'd1, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_mode", {29'd0, stk_mode}, 32'd0);
    chk("rst_word", {28'd0, stk_in_word}, 32'd0);
    chk("rst_depth", {28'd0, depth}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    reset = 1'b0;

    // Two pushes.
    push(4'd3);
    push(4'd5);
    wait_idle();
    chk("push_top", {28'd0, top_word}, 32'd5);
    chk("push_second", {28'd0, second_word}, 32'd3);
    chk("push_depth", {28'd0, depth}, 32'd2);
    chk("push_err", {31'd0, err}, 32'd0);

    // NOP has no effect.
    send(3'd0, 4'd0);
    chk("nop_mode", {29'd0, stk_mode}, 32'd0);
    chk("nop_depth", {28'd0, depth}, 32'd2);

`ifdef STACKSEQ_ARITH_EN
    expect_step(3'd2, 4'd0);
    expect_step(3'd3, 4'd8);
    send(3'd5, 4'd0);
    wait_idle();
    chk("add_top", {28'd0, top_word}, 32'd8);
    chk("add_depth", {28'd0, depth}, 32'd1);
    chk("add_carry", {31'd0, carry}, 32'd0);
    push(4'd9);
    push(4'd9);
    expect_step(3'd2, 4'd0);
    expect_step(3'd3, 4'd2);
    send(3'd5, 4'd0);
    wait_idle();
    chk("add99_top", {28'd0, top_word}, 32'd2);
    chk("add99_depth", {28'd0, depth}, 32'd2);
    chk("add99_carry", {31'd0, carry}, 32'd1);
    // 8 - 2 = 6, no borrow.
    expect_step(3'd2, 4'd0);
    expect_step(3'd3, 4'd6);
    send(3'd6, 4'd0);
    wait_idle();
    chk("sub_top", {28'd0, top_word}, 32'd6);
    chk("sub_depth", {28'd0, depth}, 32'd1);
    chk("sub_carry", {31'd0, carry}, 32'd0);
    // 3 - 5 wraps to 14 with borrow.
    send(3'd7, 4'd0);
    push(4'd3);
    push(4'd5);
    expect_step(3'd2, 4'd0);
    expect_step(3'd3, 4'd14);
    send(3'd6, 4'd0);
    wait_idle();
    chk("subb_top", {28'd0, top_word}, 32'd14);
    chk("subb_carry", {31'd0, carry}, 32'd1);
    chk("subb_err", {31'd0, err}, 32'd0);
`else
    send(3'd5, 4'd0);
    chk("add_off_mode", {29'd0, stk_mode}, 32'd0);
    chk("add_off_err", {31'd0, err}, 32'd1);
    chk("add_off_depth", {28'd0, depth}, 32'd2);
    chk("add_off_carry", {31'd0, carry}, 32'd0);
    send(3'd6, 4'd0);
    chk("sub_off_ready", {31'd0, cmd_ready}, 32'd1);
    chk("sub_off_depth", {28'd0, depth}, 32'd2);
`endif
    send(3'd7, 4'd0);
    chk("clr_depth", {28'd0, depth}, 32'd0);
    chk("clr_err", {31'd0, err}, 32'd0);
    chk("clr_carry", {31'd0, carry}, 32'd0);

    // SWAP takes three steps with cmd_ready low throughout.
    push(4'd3);
    push(4'd5);
    wait_idle();
    expect_step(3'd2, 4'd0);
    expect_step(3'd3, 4'd5);
    expect_step(3'd1, 4'd3);
    send(3'd4, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("swap_busy", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("swap_ready", {31'd0, cmd_ready}, 32'd1);
    chk("swap_top", {28'd0, top_word}, 32'd3);
    chk("swap_second", {28'd0, second_word}, 32'd5);
    chk("swap_depth", {28'd0, depth}, 32'd2);

    // Underflow.
    send(3'd7, 4'd0);
    send(3'd2, 4'd0);
    chk("unf_err", {31'd0, err}, 32'd1);
    chk("unf_depth", {28'd0, depth}, 32'd0);
    chk("unf_mode", {29'd0, stk_mode}, 32'd0);
    send(3'd7, 4'd0);
    chk("unf_clr_err", {31'd0, err}, 32'd0);

    // Overflow at DEPTH_MAX, then err stays sticky across a legal POP.
    for (int i = 1; i <= DMAX; i++) push(4'(i));
    wait_idle();
    chk("full_depth", {28'd0, depth}, DMAX);
    send(3'd1, 4'd7);
    wait_idle();
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_depth", {28'd0, depth}, DMAX);
    chk("ovf_top", {28'd0, top_word}, DMAX);
    send(3'd3, 4'd0);
    chk("ovf_dup_depth", {28'd0, depth}, DMAX);
    expect_step(3'd2, 4'd0);
    send(3'd2, 4'd0);
    wait_idle();
    chk("pop_depth", {28'd0, depth}, DMAX - 1);
    chk("pop_top", {28'd0, top_word}, DMAX - 1);
    chk("pop_err_sticky", {31'd0, err}, 32'd1);
    expect_step(3'd1, 4'(DMAX - 1));
    send(3'd3, 4'd0);
    wait_idle();
    chk("dup_second", {28'd0, second_word}, DMAX - 1);

    // Reset while SWAP sits in its LOAD step.
    send(3'd7, 4'd0);
    push(4'd3);
    push(4'd5);
    wait_idle();
    expect_step(3'd2, 4'd0);
    expect_step(3'd3, 4'd5);
    send(3'd4, 4'd0);
    @(posedge clk); #1;
    chk("mid_load_mode", {29'd0, stk_mode}, 32'd3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_mode", {29'd0, stk_mode}, 32'd0);
    chk("midrst_depth", {28'd0, depth}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_word", {28'd0, stk_in_word}, 32'd0);

    // Reset wins over a concurrent PUSH.
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 4'd9;
    @(posedge clk); #1;
    chk("rstpri_depth", {28'd0, depth}, 32'd0);
    chk("rstpri_mode", {29'd0, stk_mode}, 32'd0);
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter DEPTH_MAX, default `STACK_SIZE (from constants.v), the number of entries in the controlled stack; legal range 2..15.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_op  input  3  opcode: NOP 0, PUSH 1, POP 2, DUP 3, SWAP 4, ADD 5, SUB 6, CLEAR 7.
REQ-006 SHALL have port cmd_data  input  4  immediate for PUSH.
REQ-007 SHALL have port cmd_ready  output  1  command accepted this edge when cmd_valid&&cmd_ready.
REQ-008 SHALL have port top_word  input  4  stack entry 0 from the stack register.
REQ-009 SHALL have port second_word  input  4  stack entry 1 from the stack register.
REQ-010 SHALL have port stk_mode  output  3  registered mode to the stack register: HOLD 0, PUSH 1, POP 2, LOAD 3 (replace entry 0, others hold).
REQ-011 SHALL have port stk_in_word  output  4  registered data word to the stack register.
REQ-012 SHALL have port depth  output  4  logical occupancy, 0..DEPTH_MAX.
REQ-013 SHALL have port err  output  1  sticky overflow/underflow/illegal flag.
REQ-014 SHALL have port carry  output  1  carry (ADD) or borrow (SUB) of last completed arithmetic op.

Function
REQ-015 SHALL be a Moore FSM, states IDLE, S_PUSH, S_POP, S_LOAD; stk_mode equals the state's mode (IDLE -> HOLD); cmd_ready = (state==IDLE).
REQ-016 SHALL, on acceptance, latch t=top_word and s=second_word, check depth, and update depth, err and the next state at that same edge.
REQ-017 SHALL sequence: PUSH -> S_PUSH(cmd_data); DUP -> S_PUSH(t); POP -> S_POP; ADD/SUB -> S_POP, S_LOAD(result); SWAP -> S_POP, S_LOAD(t), S_PUSH(s); then IDLE.
REQ-018 SHALL hold stk_in_word at the current step's word; each step is applied by the stack register on the edge leaving that state.
REQ-019 SHALL compute ADD = s+t and SUB = s-t modulo 16; carry = bit 4 of the 5-bit sum/difference, set at acceptance, otherwise held.
REQ-020 SHALL update depth: PUSH/DUP +1, POP/ADD/SUB -1, SWAP/NOP unchanged, CLEAR -> 0.
REQ-021 SHALL treat as error: PUSH/DUP at depth==DEPTH_MAX; POP at depth 0; SWAP/ADD/SUB at depth<2; on error set err, consume command, keep depth, stay IDLE, stk_mode HOLD.
REQ-022 SHALL make CLEAR zero depth, err and carry in one edge with no stack step; NOP is consumed with no effect.
REQ-023 SHALL give latency (accept edge to last step applied): PUSH/DUP/POP 1, ADD/SUB 2, SWAP 3 edges; cmd_ready high again right after the last step.

Reset
REQ-024 SHALL, when reset is high at an edge, force state IDLE, stk_mode HOLD, stk_in_word 0, depth 0, err 0, carry 0, including mid-sequence; reset has priority over a concurrent command.

Configuration
REQ-025 SHALL, with STACKSEQ_ARITH_EN defined, implement ADD/SUB as above; without it, ADD/SUB SHALL set err, leave depth/carry unchanged and carry SHALL read 0.

Structure
REQ-026 SHALL take opcode and stk_mode encodings and STACK_SIZE from the shared constants.v under the existing CONSTANTS include guard.
REQ-027 SHALL keep the arithmetic in one combinational sub-module stack_alu (s, t, sub -> 4-bit result, carry), instantiated only under STACKSEQ_ARITH_EN.

Verification
REQ-028 SHALL cover: after reset, PUSH 3, PUSH 5 -> top_word 5, second_word 3, depth 2, err 0.
REQ-029 SHALL cover: stack {top 5, 3}, ADD -> stk_mode POP then LOAD(8), top_word 8, depth 1, carry 0; repeat with 9+9 -> top 2, carry 1.
REQ-030 SHALL cover: stack {top 5, 3}, SWAP -> modes POP, LOAD(5), PUSH(3), top 3, second 5, cmd_ready low 3 cycles.
REQ-031 SHALL cover: POP at depth 0 -> err 1, depth 0, stk_mode HOLD; then CLEAR -> err 0.
REQ-032 SHALL cover: DEPTH_MAX pushes then PUSH 7 -> err 1, depth stays DEPTH_MAX, top unchanged.
REQ-033 SHALL cover: reset asserted in S_LOAD of SWAP -> next cycle IDLE, stk_mode HOLD, depth 0, cmd_ready 1.
